seq_mag_comparator: RTL and testbench
=====================================

Name: seq_mag_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator; successor to the team's 1-bit equality comparator.
- Compares two WIDTH-bit operands SLICE bits per cycle, starting at the MSB slice.
- Stops at the first unequal slice and reports eq/gt/lt with a start/busy/done handshake.
- Sits beside datapath blocks that need cheap, area-light compares.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of SLICE.
SLICE, 4, bits compared per cycle; NSLICE = WIDTH/SLICE, minimum 1.

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a compare; sampled only when busy=0
a  input  WIDTH  operand A; sampled on the accepting edge
b  input  WIDTH  operand B; sampled on the accepting edge
busy  output  1  compare in progress
done  output  1  one-cycle pulse; eq/gt/lt valid and updated in this cycle
eq  output  1  last result: A == B
gt  output  1  last result: A > B
lt  output  1  last result: A < B

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: FSM in IDLE; busy=0, done=0, eq=0, gt=0, lt=0; slice counter=0; operand registers=0.
- Reset asserted mid-compare: the compare aborts immediately, outputs go to reset values, and no done is issued.
- FSM states: IDLE, CMP.
- IDLE:
  - start=1 at edge E0 latches a, b (and signed_mode if compiled in).
  - Loads slice counter with NSLICE-1, sets busy=1, and moves to CMP.
- CMP, each edge:
  - Compares slice[cnt] of A against slice[cnt] of B as unsigned SLICE-bit values.
  - Slices differ: gt/lt set accordingly, eq=0, done=1, busy=0, go to IDLE.
  - Slices equal and cnt==0: eq=1, gt=0, lt=0, done=1, busy=0, go to IDLE.
  - Slices equal and cnt>0: cnt decrements and the FSM stays in CMP.
- Latency: done is asserted k cycles after E0, where k is the number of slices examined (1..NSLICE). Worst case is NSLICE cycles.
- Result outputs:
  - Exactly one of eq/gt/lt is high after the first compare completes.
  - They hold their value until the next done and do not change while busy.
- done is high for exactly one cycle and is never asserted while busy=1.
- start while busy=1 is ignored, with no effect on the in-flight compare.
- start in the done cycle is accepted (FSM is already IDLE), so back-to-back compares run with zero idle cycles.
- a/b may change freely after the accepting edge; only the latched copies are used.
- NSLICE=1: every compare completes in 1 cycle.

Optional Feature:
- Macro: CMP_SIGNED_EN.
- Defined:
  - Adds input port signed_mode (1 bit), latched with the operands at start.
  - When signed_mode=1, the operands are treated as two's complement: the sign bit (bit WIDTH-1) of each latched operand is inverted before the MSB-slice compare.
  - Latency rules are unchanged.
- Not defined:
  - The port is absent and all compares are unsigned.
  - Logic is identical to the signed_mode=0 case.

Test Plan:
- Equal operands: WIDTH=16, SLICE=4, a=b=16'hA5A5, start 1 cycle -> busy high 4 cycles; done pulse on 4th cycle after the accepting edge; eq=1, gt=0, lt=0.
- Early exit: a=16'h8000, b=16'h7FFF -> done 1 cycle after accept; gt=1. Then a=16'h1234, b=16'h1235 -> done after 4 cycles; lt=1.
- Start while busy: a=16'h0001, b=16'h0001 accepted, then start with a=16'hFFFF, b=0 one cycle later -> ignored; done after 4 cycles with eq=1; only one done pulse.
- Back-to-back: start held high across the done cycle with a=16'h0F00, b=16'h0E00 -> second compare accepted in the done cycle; its done follows 2 cycles later with gt=1; results unchanged between the two dones.
- Reset mid-op: rst asserted 2 cycles into a 4-slice compare -> busy, done, eq, gt, lt are 0 immediately (asynchronous); no done after release; a new start works normally.
- CMP_SIGNED_EN defined: a=16'h8000, b=16'h0001, signed_mode=1 -> lt=1 after 1 cycle; same operands with signed_mode=0 -> gt=1 after 1 cycle.

Source files
------------

// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: multi-cycle magnitude compare, SLICE bits per cycle,
// MSB slice first, early exit on the first unequal slice.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   start         request a compare (sampled only while busy=0)
//   signed_mode   two's-complement compare (only when CMP_SIGNED_EN is defined)
//   a, b          operands, latched on the accepting edge
//   busy          compare in progress
//   done          one-cycle pulse, eq/gt/lt updated in this cycle
//   eq, gt, lt    last result, held until the next done
//
// Optional feature macro: CMP_SIGNED_EN (adds signed_mode).

module seq_mag_comparator #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef CMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0]    LAST = CW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] MSB  = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic {
    IDLE,
    CMP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  logic [WIDTH-1:0] flip;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic             last;

  // Flipping the sign bit maps two's complement onto unsigned order,
  // so the slice compare itself never needs to know about signedness.
`ifdef CMP_SIGNED_EN
  assign flip = signed_mode ? MSB : '0;
`else
  assign flip = '0;
`endif

  assign a_sh = a_q >> (int'(cnt_q) * SLICE);
  assign b_sh = b_q >> (int'(cnt_q) * SLICE);
  assign sa   = a_sh[SLICE-1:0];
  assign sb   = b_sh[SLICE-1:0];
  assign last = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a ^ flip;
          b_d     = b ^ flip;
          cnt_d   = LAST;
          state_d = CMP;
        end
      end
      CMP: begin
        unique case (1'b1)
          (sa > sb): begin
            {eq_d, gt_d, lt_d} = 3'b010;
            done_d  = 1'b1;
            state_d = IDLE;
          end
          (sa < sb): begin
            {eq_d, gt_d, lt_d} = 3'b001;
            done_d  = 1'b1;
            state_d = IDLE;
          end
          (sa == sb && last): begin
            {eq_d, gt_d, lt_d} = 3'b100;
            done_d  = 1'b1;
            state_d = IDLE;
          end
          default: begin
            cnt_d = cnt_q - CW'(1);
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == CMP);
  assign done = done_q;
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// tb_seq_mag_comparator: directed vector table plus hand-written
// sequences for busy-start, back-to-back, reset abort and signed mode.

module tb_seq_mag_comparator;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sm;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic        eq;
  logic        gt;
  logic        lt;

  int n_chk;
  int n_fail;

  seq_mag_comparator #(
    .WIDTH(16),
    .SLICE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
`ifdef CMP_SIGNED_EN
    .signed_mode(sm),
`endif
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .eq(eq),
    .gt(gt),
    .lt(lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          k;
    logic [2:0]  res;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits for done (bounded), checks latency, result hold while busy.
  task automatic wait_done(input string name, input int exp_k,
                           input logic [2:0] exp_res, output int k);
    logic [2:0] held;
    held = {eq, gt, lt};
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      k++;
      if (done) break;
      if ({eq, gt, lt} != held) begin
        chk({name, " hold"}, int'({eq, gt, lt}), int'(held));
      end
      if (k > 8) begin
        chk({name, " timeout"}, k, exp_k);
        return;
      end
    end
    chk({name, " lat"}, k, exp_k);
    chk({name, " res"}, int'({eq, gt, lt}), int'(exp_res));
    chk({name, " busy@done"}, int'(busy), 0);
  endtask

  task automatic run_cmp(input string name, input logic [15:0] va,
                         input logic [15:0] vb, input int exp_k,
                         input logic [2:0] exp_res);
    int k;
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~va;
    b = ~vb;
    chk({name, " busy"}, int'(busy), 1);
    wait_done(name, exp_k, exp_res, k);
    @(posedge clk);
    #1;
    chk({name, " pulse"}, int'(done), 0);
  endtask

  vec_t vecs [10];

  initial begin
    int k;
    int ndone;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    start  = 1'b0;
    sm     = 1'b0;
    a      = '0;
    b      = '0;

    vecs[0] = '{16'hA5A5, 16'hA5A5, 4, 3'b100};
    vecs[1] = '{16'h8000, 16'h7FFF, 1, 3'b010};
    vecs[2] = '{16'h1234, 16'h1235, 4, 3'b001};
    vecs[3] = '{16'h0000, 16'h0000, 4, 3'b100};
    vecs[4] = '{16'hFFFF, 16'h0000, 1, 3'b010};
    vecs[5] = '{16'h0F00, 16'h0E00, 2, 3'b010};
    vecs[6] = '{16'h00A0, 16'h00B0, 3, 3'b001};
    vecs[7] = '{16'hABCD, 16'hABCC, 4, 3'b010};
    vecs[8] = '{16'h0001, 16'h8000, 1, 3'b001};
    vecs[9] = '{16'h1200, 16'h1300, 2, 3'b001};

    repeat (2) @(posedge clk);
    #1;
    chk("rst outs", int'({busy, done, eq, gt, lt}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle outs", int'({busy, done, eq, gt, lt}), 0);

    for (int i = 0; i < 10; i++) begin
      run_cmp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
              vecs[i].k, vecs[i].res);
    end

    // start while busy is ignored
    @(negedge clk);
    a = 16'h0001;
    b = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    a = 16'hFFFF;
    b = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        chk("busystart lat", c, 2);
        chk("busystart res", int'({eq, gt, lt}), 4);
      end
    end
    chk("busystart ndone", ndone, 1);

    // back-to-back: start held across the done cycle
    @(negedge clk);
    a = 16'h0F00;
    b = 16'h0E00;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done("b2b1", 2, 3'b010, k);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b accept busy", int'(busy), 1);
    chk("b2b done low", int'(done), 0);
    chk("b2b held", int'({eq, gt, lt}), 2);
    wait_done("b2b2", 2, 3'b010, k);

    // reset aborts a compare in flight
    @(negedge clk);
    a = 16'hA5A5;
    b = 16'hA5A5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("pre-rst busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("async rst outs", int'({busy, done, eq, gt, lt}), 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("post-rst no done", ndone, 0);
    run_cmp("after rst", 16'h1234, 16'h1235, 4, 3'b001);

`ifdef CMP_SIGNED_EN
    sm = 1'b1;
    run_cmp("signed", 16'h8000, 16'h0001, 1, 3'b001);
    sm = 1'b0;
    run_cmp("unsigned", 16'h8000, 16'h0001, 1, 3'b010);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  // done must never coincide with busy
  always @(negedge clk) begin
    if (!rst && done && busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL done&busy: got done=1 busy=1 expected busy=0");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
